sqrt_arbiter: RTL

//  Shares one fixed-latency sqrtFixedPoint core among N_REQ requesters.
//  - Round-robin arbiter issues at most one operand per cycle to the core.
//  - An ID tag pipeline matched to core latency routes each result back with its requester ID.
//  - A result FIFO with credit control absorbs output back-pressure, since the core itself cannot stall.
//  - Sits between DSP filter channels and a single shared sqrt instance.

---
 rtl/sqrt_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sqrt_arbiter.sv
// Round-robin front end that shares one fixed-latency sqrt core among N_REQ requesters,
// with an ID tag pipe and a credit-bounded result FIFO. Optional SQRT_ARBITER_STATS_EN adds grant counters.
module sqrt_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = 8,
    parameter int RES_W      = 8,
    parameter int CORE_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    output logic [N_REQ-1:0]          o_req_ready,
    output logic                      o_core_valid,
    output logic [DATA_W-1:0]         o_core_data,
    input  logic                      i_core_valid,
    input  logic [RES_W-1:0]          i_core_data,
    output logic                      o_res_valid,
    input  logic                      i_res_ready,
    output logic [RES_W-1:0]          o_res_data,
    output logic [$clog2(N_REQ)-1:0]  o_res_id,
    output logic                      o_err
`ifdef SQRT_ARBITER_STATS_EN
    ,
    output logic [16*N_REQ-1:0]       o_grant_cnt
`endif
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = ID_W + RES_W;

    logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]         credit_q, credit_d;
    logic [CORE_LAT-1:0]      tag_vld_q, tag_vld_d;
    logic [CORE_LAT*ID_W-1:0] tag_id_q, tag_id_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         fill_q, fill_d;
    logic                     err_q, err_d;
    logic [ENT_W-1:0]         fifo_mem_q [FIFO_DEPTH];

    logic [N_REQ-1:0]         grant;
    logic [ID_W-1:0]          gnt_id;
    logic [ID_W-1:0]          cand;
    logic                     found;
    logic                     issue;
    logic                     head_vld;
    logic [ID_W-1:0]          head_id;
    logic                     push;
    logic                     pop;
    logic [ENT_W-1:0]         fifo_head;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        cand   = '0;
        found  = 1'b0;
        if (credit_q != '0) begin
            for (int i = 1; i <= N_REQ; i++) begin
                cand = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
                if (!found && i_req_valid[cand]) begin
                    found  = 1'b1;
                    gnt_id = cand;
                end
            end
        end
        if (found) begin
            grant[gnt_id] = 1'b1;
        end
    end

    assign issue        = found;
    assign o_req_ready  = grant;
    assign o_core_valid = issue;
    assign o_core_data  = issue ? i_req_data[int'(gnt_id)*DATA_W +: DATA_W] : '0;

    assign tag_vld_d[0]        = issue;
    assign tag_id_d[0 +: ID_W] = gnt_id;
    for (genvar gi = 1; gi < CORE_LAT; gi++) begin : g_tag
        assign tag_vld_d[gi]            = tag_vld_q[gi-1];
        assign tag_id_d[gi*ID_W +: ID_W] = tag_id_q[(gi-1)*ID_W +: ID_W];
    end

    assign head_vld    = tag_vld_q[CORE_LAT-1];
    assign head_id     = tag_id_q[(CORE_LAT-1)*ID_W +: ID_W];
    assign push        = i_core_valid & head_vld;
    assign o_res_valid = (fill_q != '0);
    assign pop         = o_res_valid & i_res_ready;
    assign fifo_head   = fifo_mem_q[rd_ptr_q];
    assign o_res_data  = o_res_valid ? fifo_head[RES_W-1:0] : '0;
    assign o_res_id    = o_res_valid ? fifo_head[ENT_W-1:RES_W] : '0;
    assign o_err       = err_q;

    always_comb begin
        rr_ptr_d = issue ? gnt_id : rr_ptr_q;
        credit_d = credit_q - CNT_W'(issue) + CNT_W'(pop);
        fill_d   = fill_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        // A core result arriving with no tag means the core and tag pipe disagree.
        err_d = err_q | (i_core_valid & ~head_vld);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_ptr_q  <= '0;
            credit_q  <= CNT_W'(FIFO_DEPTH);
            tag_vld_q <= '0;
            tag_id_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            credit_q  <= credit_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            err_q     <= err_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {head_id, i_core_data};
        end
    end

`ifdef SQRT_ARBITER_STATS_EN
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
        logic [15:0] cnt_q, cnt_d;
        always_comb begin
            cnt_d = cnt_q;
            if (grant[gi] && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
        assign o_grant_cnt[gi*16 +: 16] = cnt_q;
    end
`endif

endmodule
